// File: rtl/ex_issue_stage_pkg.sv
// Shared core definitions for the RV32 pipeline: datapath widths, result-source
// encodings, ALU op codes and a register-match helper used by hazard/forward logic.
package ex_issue_stage_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    // Source of the value written back to rd.
    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } resultsrc_e;

    // ALU op codes, shared with the ALU and its decoder.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // True when a source index reads a destination; x0 never matches.
    function automatic logic reg_match(input logic [REGW-1:0] src,
                                       input logic [REGW-1:0] dst);
        return (src != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/ex_issue_stage_fwd_mux.sv
// Operand forward mux: picks the youngest in-flight producer of a source
// register (MEM over WB), falling back to the register-file value.
module fwd_mux
    import ex_issue_stage_pkg::reg_match;
#(
    parameter int XLEN = ex_issue_stage_pkg::XLEN,
    parameter int REGW = ex_issue_stage_pkg::REGW
) (
    input  logic [REGW-1:0] idx,
    input  logic [XLEN-1:0] reg_val,
    input  logic [REGW-1:0] mem_rd,
    input  logic            mem_regwrite,
    input  logic [XLEN-1:0] mem_aluresult,
    input  logic [REGW-1:0] wb_rd,
    input  logic            wb_regwrite,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] value
);

    // Select the operand source; MEM is younger than WB so it is checked first.
    always_comb begin
        // NOTE: default first so every path assigns value and no latch is inferred.
        value = reg_val;
        if (mem_regwrite && reg_match(idx, mem_rd)) begin
            value = mem_aluresult;
        end else if (wb_regwrite && reg_match(idx, wb_rd)) begin
            value = wb_result;
        end
    end

endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX pipeline register and EX operand selection for the five-stage RV32 core.
// Owns the load-use / RAW stall of decode and the flush bubble of the EX slot.
// Build option: define EX_FORWARD_EN to enable MEM/WB operand forwarding with a
// load-use-only stall; otherwise every RAW dependence stalls until the writer
// has left WB.
module ex_issue_stage
    import ex_issue_stage_pkg::reg_match;
    import ex_issue_stage_pkg::RES_LOAD;
#(
    parameter int XLEN = ex_issue_stage_pkg::XLEN,
    parameter int REGW = ex_issue_stage_pkg::REGW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic [XLEN-1:0] id_rd1,
    input  logic [XLEN-1:0] id_rd2,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_alusrc,
    input  logic [3:0]      id_alucontrol,
    input  logic            id_regwrite,
    input  logic [1:0]      id_resultsrc,
    input  logic            flush,
    input  logic [REGW-1:0] mem_rd,
    input  logic [REGW-1:0] wb_rd,
    input  logic            mem_regwrite,
    input  logic            wb_regwrite,
    input  logic [XLEN-1:0] mem_aluresult,
    input  logic [XLEN-1:0] wb_result,
    output logic            ex_valid,
    output logic [XLEN-1:0] SrcA,
    output logic [XLEN-1:0] SrcB,
    output logic [3:0]      ALUControl,
    output logic [XLEN-1:0] ex_wdata,
    output logic [REGW-1:0] ex_rd,
    output logic            ex_regwrite,
    output logic [1:0]      ex_resultsrc
);

    // Everything held in the EX slot; an all-zero value is a bubble.
    typedef struct packed {
        logic            valid;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic            alusrc;
        logic [3:0]      alucontrol;
        logic            regwrite;
        logic [1:0]      resultsrc;
    } ex_reg_t;

    ex_reg_t         ex_q;
    logic            hazard;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

    assign ex_valid     = ex_q.valid;
    assign ex_rd        = ex_q.rd;
    assign ex_resultsrc = ex_q.resultsrc;
    assign ex_regwrite  = ex_q.valid & ex_q.regwrite;
    assign ALUControl   = ex_q.alucontrol;

`ifdef EX_FORWARD_EN
    // Only a load in EX cannot be forwarded in time: stall decode one cycle.
    always_comb begin
        hazard = 1'b0;
        if (id_valid && ex_q.valid && (ex_q.resultsrc == RES_LOAD) &&
            (reg_match(id_rs1, ex_q.rd) || reg_match(id_rs2, ex_q.rd))) begin
            hazard = 1'b1;
        end
    end

    fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_a (
        .idx           (ex_q.rs1),
        .reg_val       (ex_q.rd1),
        .mem_rd        (mem_rd),
        .mem_regwrite  (mem_regwrite),
        .mem_aluresult (mem_aluresult),
        .wb_rd         (wb_rd),
        .wb_regwrite   (wb_regwrite),
        .wb_result     (wb_result),
        .value         (fwd_a)
    );

    fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_b (
        .idx           (ex_q.rs2),
        .reg_val       (ex_q.rd2),
        .mem_rd        (mem_rd),
        .mem_regwrite  (mem_regwrite),
        .mem_aluresult (mem_aluresult),
        .wb_rd         (wb_rd),
        .wb_regwrite   (wb_regwrite),
        .wb_result     (wb_result),
        .value         (fwd_b)
    );
`else
    // Without forwarding the registered indices and bypass data have no reader.
    logic unused_fwd;
    assign unused_fwd = ^{mem_aluresult, wb_result, ex_q.rs1, ex_q.rs2};

    // Stall while any live writer in EX, MEM or WB targets a source register.
    always_comb begin
        hazard = 1'b0;
        if (id_valid &&
            ((ex_regwrite  && (reg_match(id_rs1, ex_q.rd) || reg_match(id_rs2, ex_q.rd))) ||
             (mem_regwrite && (reg_match(id_rs1, mem_rd)  || reg_match(id_rs2, mem_rd)))  ||
             (wb_regwrite  && (reg_match(id_rs1, wb_rd)   || reg_match(id_rs2, wb_rd))))) begin
            hazard = 1'b1;
        end
    end

    assign fwd_a = ex_q.rd1;
    assign fwd_b = ex_q.rd2;
`endif

    assign id_ready = ~hazard;
    assign SrcA     = fwd_a;
    assign SrcB     = ex_q.alusrc ? ex_q.imm : fwd_b;
    assign ex_wdata = fwd_b;

    // EX slot register: reset and flush/stall load a bubble, otherwise capture decode.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep all state updating together at the edge.
        if (reset || flush || hazard) begin
            ex_q <= '0;
        end else begin
            ex_q.valid      <= id_valid;
            ex_q.rs1        <= id_rs1;
            ex_q.rs2        <= id_rs2;
            ex_q.rd         <= id_rd;
            ex_q.rd1        <= id_rd1;
            ex_q.rd2        <= id_rd2;
            ex_q.imm        <= id_imm;
            ex_q.alusrc     <= id_alusrc;
            ex_q.alucontrol <= id_alucontrol;
            ex_q.regwrite   <= id_regwrite;
            ex_q.resultsrc  <= id_resultsrc;
        end
    end

endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed self-checking bench for ex_issue_stage. Expected values are
// hand-computed; the EX_FORWARD_EN build selects the matching directed steps.
module tb_ex_issue_stage;
    import ex_issue_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rd1, id_rd2, id_imm;
    logic        id_alusrc;
    logic [3:0]  id_alucontrol;
    logic        id_regwrite;
    logic [1:0]  id_resultsrc;
    logic        flush;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_regwrite, wb_regwrite;
    logic [31:0] mem_aluresult, wb_result;
    logic        ex_valid;
    logic [31:0] SrcA, SrcB, ex_wdata;
    logic [3:0]  ALUControl;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic [1:0]  ex_resultsrc;

    int n_checks = 0;
    int n_fail   = 0;

    ex_issue_stage dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_rd1        (id_rd1),
        .id_rd2        (id_rd2),
        .id_imm        (id_imm),
        .id_alusrc     (id_alusrc),
        .id_alucontrol (id_alucontrol),
        .id_regwrite   (id_regwrite),
        .id_resultsrc  (id_resultsrc),
        .flush         (flush),
        .mem_rd        (mem_rd),
        .wb_rd         (wb_rd),
        .mem_regwrite  (mem_regwrite),
        .wb_regwrite   (wb_regwrite),
        .mem_aluresult (mem_aluresult),
        .wb_result     (wb_result),
        .ex_valid      (ex_valid),
        .SrcA          (SrcA),
        .SrcB          (SrcB),
        .ALUControl    (ALUControl),
        .ex_wdata      (ex_wdata),
        .ex_rd         (ex_rd),
        .ex_regwrite   (ex_regwrite),
        .ex_resultsrc  (ex_resultsrc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                            input logic [31:0] imm, input logic alusrc, input logic [3:0] op,
                            input logic rw, input logic [1:0] rsrc);
        id_valid      = v;
        id_rs1        = rs1;
        id_rs2        = rs2;
        id_rd         = rd;
        id_rd1        = rd1;
        id_rd2        = rd2;
        id_imm        = imm;
        id_alusrc     = alusrc;
        id_alucontrol = op;
        id_regwrite   = rw;
        id_resultsrc  = rsrc;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 2'b00);
        mem_rd = 5'd0; wb_rd = 5'd0;
        mem_regwrite = 1'b0; wb_regwrite = 1'b0;
        mem_aluresult = 32'h0; wb_result = 32'h0;

        // Reset state
        tick();
        check("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
        check("rst_srca", SrcA, 32'h0);
        check("rst_srcb", SrcB, 32'h0);
        check("rst_alucontrol", {28'b0, ALUControl}, 32'h0);
        check("rst_wdata", ex_wdata, 32'h0);
        check("rst_ex_rd", {27'b0, ex_rd}, 32'h0);
        check("rst_regwrite", {31'b0, ex_regwrite}, 32'h0);
        check("rst_resultsrc", {30'b0, ex_resultsrc}, 32'h0);
        check("rst_id_ready", {31'b0, id_ready}, 32'h1);
        reset = 1'b0;

        // add x3,x1,x2 with rd1=5, rd2=7
        drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 1'b0, ALU_ADD, 1'b1, RES_ALU);
        settle();
        check("add_id_ready_pre", {31'b0, id_ready}, 32'h1);
        tick();
        check("add_srca", SrcA, 32'd5);
        check("add_srcb", SrcB, 32'd7);
        check("add_ex_valid", {31'b0, ex_valid}, 32'h1);
        check("add_regwrite", {31'b0, ex_regwrite}, 32'h1);
        check("add_ex_rd", {27'b0, ex_rd}, 32'd3);
        check("add_wdata", ex_wdata, 32'd7);
        check("add_id_ready_post", {31'b0, id_ready}, 32'h1);

        // addi-style x6,x1,0x40: SrcB takes the immediate, store data keeps rd2
        drive_id(1'b1, 5'd1, 5'd0, 5'd6, 32'd5, 32'h99, 32'h40, 1'b1, ALU_SUB, 1'b1, RES_ALU);
        settle();
        check("imm_id_ready", {31'b0, id_ready}, 32'h1);
        tick();
        check("imm_srca", SrcA, 32'd5);
        check("imm_srcb", SrcB, 32'h40);
        check("imm_wdata", ex_wdata, 32'h99);
        check("imm_alucontrol", {28'b0, ALUControl}, {28'b0, ALU_SUB});
        check("imm_ex_rd", {27'b0, ex_rd}, 32'd6);

`ifdef EX_FORWARD_EN
        // MEM forward wins over WB for the same register
        mem_rd = 5'd1; mem_regwrite = 1'b1; mem_aluresult = 32'h10;
        wb_rd = 5'd1; wb_regwrite = 1'b1; wb_result = 32'h20;
        settle();
        check("fwd_mem_priority", SrcA, 32'h10);
        mem_regwrite = 1'b0;
        settle();
        check("fwd_wb", SrcA, 32'h20);
        wb_regwrite = 1'b0;

        // x0 is never forwarded
        drive_id(1'b1, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, 1'b0, ALU_ADD, 1'b1, RES_ALU);
        tick();
        mem_rd = 5'd0; mem_regwrite = 1'b1; mem_aluresult = 32'hFF;
        settle();
        check("fwd_x0_guard", SrcA, 32'h0);
        mem_regwrite = 1'b0;

        // lw x5 then add x6,x5,x2: one bubble, then WB-forwarded operand
        drive_id(1'b1, 5'd1, 5'd0, 5'd5, 32'd5, 32'h0, 32'h4, 1'b1, ALU_ADD, 1'b1, RES_LOAD);
        tick();
        drive_id(1'b1, 5'd5, 5'd2, 5'd6, 32'h0, 32'd7, 32'h0, 1'b0, ALU_ADD, 1'b1, RES_ALU);
        settle();
        check("lu_id_ready_stall", {31'b0, id_ready}, 32'h0);
        tick();
        check("lu_bubble", {31'b0, ex_valid}, 32'h0);
        check("lu_id_ready_release", {31'b0, id_ready}, 32'h1);
        tick();
        wb_rd = 5'd5; wb_regwrite = 1'b1; wb_result = 32'h55;
        settle();
        check("lu_srca_fwd", SrcA, 32'h55);
        check("lu_ex_valid", {31'b0, ex_valid}, 32'h1);
        check("lu_ex_rd", {27'b0, ex_rd}, 32'd6);
        wb_regwrite = 1'b0; wb_rd = 5'd0;
`else
        // add x8,x6,x2 right behind the writer of x6: three stall cycles
        drive_id(1'b1, 5'd6, 5'd2, 5'd8, 32'h11, 32'd7, 32'h0, 1'b0, ALU_ADD, 1'b1, RES_ALU);
        settle();
        check("dep_stall_ex", {31'b0, id_ready}, 32'h0);
        tick();
        check("dep_bubble_valid", {31'b0, ex_valid}, 32'h0);
        check("dep_bubble_regwrite", {31'b0, ex_regwrite}, 32'h0);
        check("dep_bubble_rd", {27'b0, ex_rd}, 32'h0);
        check("dep_bubble_srca", SrcA, 32'h0);
        mem_rd = 5'd6; mem_regwrite = 1'b1; mem_aluresult = 32'hAAA;
        settle();
        check("dep_stall_mem", {31'b0, id_ready}, 32'h0);
        tick();
        check("dep_bubble2", {31'b0, ex_valid}, 32'h0);
        mem_regwrite = 1'b0; mem_rd = 5'd0;
        wb_rd = 5'd6; wb_regwrite = 1'b1; wb_result = 32'hBBB;
        settle();
        check("dep_stall_wb", {31'b0, id_ready}, 32'h0);
        tick();
        check("dep_bubble3", {31'b0, ex_valid}, 32'h0);
        wb_regwrite = 1'b0; wb_rd = 5'd0;
        id_rd1 = 32'h66;
        settle();
        check("dep_release", {31'b0, id_ready}, 32'h1);
        tick();
        check("dep_srca_regfile", SrcA, 32'h66);
        check("dep_srcb", SrcB, 32'd7);
        check("dep_ex_valid", {31'b0, ex_valid}, 32'h1);
        check("dep_ex_rd", {27'b0, ex_rd}, 32'd8);

        // x0 source never stalls, even against a live x0 "writer"
        drive_id(1'b1, 5'd0, 5'd2, 5'd9, 32'h0, 32'h0, 32'h0, 1'b0, ALU_ADD, 1'b1, RES_ALU);
        mem_rd = 5'd0; mem_regwrite = 1'b1;
        settle();
        check("x0_no_stall", {31'b0, id_ready}, 32'h1);
        // rs2 against a MEM writer does stall
        id_rs2 = 5'd9; mem_rd = 5'd9;
        settle();
        check("rs2_mem_stall", {31'b0, id_ready}, 32'h0);
        mem_regwrite = 1'b0; mem_rd = 5'd0;
`endif

        // lw x10 then a reader of x10 with a simultaneous flush: bubble
        drive_id(1'b1, 5'd1, 5'd0, 5'd10, 32'd3, 32'd4, 32'h0, 1'b1, ALU_ADD, 1'b1, RES_LOAD);
        tick();
        check("lw_resultsrc", {30'b0, ex_resultsrc}, {30'b0, RES_LOAD});
        drive_id(1'b1, 5'd10, 5'd0, 5'd12, 32'h1, 32'h2, 32'h0, 1'b0, ALU_ADD, 1'b1, RES_ALU);
        flush = 1'b1;
        settle();
        check("flush_stall_ready", {31'b0, id_ready}, 32'h0);
        tick();
        check("flush_stall_valid", {31'b0, ex_valid}, 32'h0);
        check("flush_stall_regwrite", {31'b0, ex_regwrite}, 32'h0);

        // Flush alone of an independent instruction
        drive_id(1'b1, 5'd1, 5'd2, 5'd11, 32'd5, 32'd7, 32'h0, 1'b0, ALU_ADD, 1'b1, RES_ALU);
        settle();
        check("flush_only_ready", {31'b0, id_ready}, 32'h1);
        tick();
        check("flush_only_valid", {31'b0, ex_valid}, 32'h0);
        check("flush_only_rd", {27'b0, ex_rd}, 32'h0);
        flush = 1'b0;

        // id_valid=0 captures an empty slot: regwrite is gated
        drive_id(1'b0, 5'd1, 5'd2, 5'd11, 32'd5, 32'd7, 32'h0, 1'b0, ALU_ADD, 1'b1, RES_ALU);
        tick();
        check("idle_valid", {31'b0, ex_valid}, 32'h0);
        check("idle_regwrite", {31'b0, ex_regwrite}, 32'h0);

        // Non-writing instruction in EX is no hazard source
        drive_id(1'b1, 5'd1, 5'd2, 5'd13, 32'd5, 32'd7, 32'h0, 1'b0, ALU_ADD, 1'b0, RES_ALU);
        tick();
        drive_id(1'b1, 5'd13, 5'd0, 5'd14, 32'd1, 32'd2, 32'h0, 1'b0, ALU_ADD, 1'b1, RES_ALU);
        settle();
        check("nowrite_no_stall", {31'b0, id_ready}, 32'h1);

        // Reset during a load-use stall clears everything
        drive_id(1'b1, 5'd1, 5'd0, 5'd10, 32'd3, 32'd4, 32'h0, 1'b1, ALU_ADD, 1'b1, RES_LOAD);
        tick();
        drive_id(1'b1, 5'd10, 5'd0, 5'd12, 32'h1, 32'h2, 32'h0, 1'b0, ALU_ADD, 1'b1, RES_ALU);
        settle();
        check("rst_stall_pre", {31'b0, id_ready}, 32'h0);
        reset = 1'b1;
        tick();
        check("rst_stall_valid", {31'b0, ex_valid}, 32'h0);
        check("rst_stall_rd", {27'b0, ex_rd}, 32'h0);
        check("rst_stall_srca", SrcA, 32'h0);
        check("rst_stall_srcb", SrcB, 32'h0);
        check("rst_stall_resultsrc", {30'b0, ex_resultsrc}, 32'h0);
        check("rst_stall_ready", {31'b0, id_ready}, 32'h1);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_issue_stage.md
# ex_issue_stage

ID/EX pipeline stage of the five-stage RV32 core. It registers decoded operands and control from decode, then resolves RAW hazards by forwarding from MEM/WB or by stalling decode. It drives the ALU operand inputs (SrcA, SrcB, ALUControl) and passes the EX-stage control fields downstream. It owns the load-use stall and the branch/jump flush bubble for the EX slot.

## Interface
Parameters:
- XLEN, 32, datapath width
- REGW, 5, register index width

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  decode slot holds an instruction
- id_ready  out  1  stage accepts decode slot this cycle (0 = stall IF/ID)
- id_rs1, id_rs2  in  REGW  source indices
- id_rd  in  REGW  destination index
- id_rd1, id_rd2  in  XLEN  register-file read data
- id_imm  in  XLEN  extended immediate
- id_alusrc  in  1  1 = SrcB takes immediate
- id_alucontrol  in  4  ALU op code, passed through unchanged
- id_regwrite  in  1  instruction writes rd
- id_resultsrc  in  2  00 ALU, 01 load, 10 PC+4
- flush  in  1  kill the instruction entering EX (taken branch/jump)
- mem_rd, wb_rd  in  REGW  destinations in MEM and WB
- mem_regwrite, wb_regwrite  in  1  MEM/WB write enables (already valid-qualified)
- mem_aluresult, wb_result  in  XLEN  forwarding sources
- ex_valid  out  1  EX slot holds a live instruction
- SrcA, SrcB  out  XLEN  ALU operands
- ALUControl  out  4  ALU op
- ex_wdata  out  XLEN  forwarded rs2 value (store data)
- ex_rd  out  REGW; ex_regwrite  out  1; ex_resultsrc  out  2

## Operation
- Each rising edge: if reset, clear all registers. Else if flush or hazard, load a bubble (ex_valid=0, ex_regwrite=0, other fields 0). Else capture the id_* fields, with ex_valid=id_valid.
- ex_regwrite output is ex_valid & registered regwrite.
- hazard is combinational: id_valid & a RAW condition (defined under Configuration). id_ready = ~hazard. When id_ready=0, IF/ID holds its contents.
- Forward mux for operand X (rs1→A, rs2→B), evaluated on registered fields:
  - mem_regwrite & mem_rd==rsX & rsX!=0 → mem_aluresult
  - else wb_regwrite & wb_rd==rsX & rsX!=0 → wb_result
  - else registered rdX
  - MEM wins over WB.
- SrcA = fwdA. SrcB = alusrc ? imm : fwdB. ex_wdata = fwdB, always.
- Register x0 is never a hazard source and never forwarded.
- Priority: reset > flush > hazard > capture. flush during a stall yields a bubble. IF/ID is flushed by its own logic.

## Timing
- Latency: 1 cycle from decode to ALU inputs. Forward muxes are combinational within the EX cycle.
- A load-use stall costs exactly 1 bubble cycle. id_ready returns to 1 on the following cycle.
- Reset values: all outputs 0. id_ready=1 (because ex_valid=0 and id_valid is gated).
- Reset asserted mid-stall clears the stall on the next edge.

## Configuration
Macro EX_FORWARD_EN.
- Defined:
  - Forwarding as above.
  - RAW condition is load-use only: ex_valid & ex_resultsrc==01 & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
- Undefined:
  - Forward muxes are removed; operands come from registered rd1/rd2.
  - RAW condition is any match of id_rs1/id_rs2 (nonzero) against a live writer: ex_rd (ex_regwrite), mem_rd (mem_regwrite) or wb_rd (wb_regwrite).
  - Stall is held until no match remains, up to 3 cycles.

## Structure
- Shared core package holds:
  - resultsrc encodings: RES_ALU=2'b00, RES_LOAD=2'b01, RES_PC4=2'b10
  - the 4-bit ALU op constants, shared with the ALU and its decoder
  - XLEN and REGW
- One sub-module, fwd_mux, instantiated twice: inputs are index, register value, MEM/WB sources; output is the selected value.
- Hazard detection is inline.

## Test plan
- Straight-line: add x3,x1,x2 with rd1=5, rd2=7, no hazards → next cycle SrcA=5, SrcB=7, ex_valid=1, id_ready held 1.
- MEM forward: EX reads x1 while mem_rd=1, mem_regwrite=1, mem_aluresult=0x10 and wb_rd=1, wb_result=0x20 → SrcA=0x10 (MEM priority).
- x0 guard: rs1=0, mem_rd=0, mem_regwrite=1, mem_aluresult=0xFF → SrcA=registered rd1 (0).
- Load-use: lw x5 in EX, decode reads x5 → id_ready=0 for one cycle, ex_valid=0 next cycle, then the instruction issues with WB-forwarded value.
- Flush with a simultaneous load-use stall → bubble loaded, ex_regwrite=0. Reset during the stall → all outputs 0, id_ready=1.
- EX_FORWARD_EN undefined: dependent add 1 cycle after the writer → id_ready=0 for 3 cycles, then SrcA=register-file value.
